// File: rtl/aes_shift_rows_pipe.sv
// Elastic AES ShiftRows/InvShiftRows stage with a tag sideband and PIPE_STAGES register stages.
// Optional feature: define AES_SHIFT_ROWS_BYPASS_EN to add an i_bypass port that passes beats unrotated.
module aes_shift_rows_pipe #(
   parameter int PIPE_STAGES = 1,
   parameter int TAG_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [127:0]     i_data,
   input  logic             i_inv,
   input  logic [TAG_W-1:0] i_tag,
`ifdef AES_SHIFT_ROWS_BYPASS_EN
   input  logic             i_bypass,
`endif
   output logic             o_valid,
   input  logic             i_ready,
   output logic [127:0]     o_data,
   output logic [TAG_W-1:0] o_tag,
   output logic [2:0]       o_count
);

   // An out-of-range depth elaborates a module that does not exist.
   generate
      if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_pipe_stages
         aes_shift_rows_pipe_pipe_stages_out_of_range u_bad ();
      end
   endgenerate

   // Byte s[r,c] lives at bits 127-8*(4c+r); row r is rotated left by r (forward) or right by r (inverse).
   function automatic logic [127:0] shift_rows(input logic [127:0] d, input logic inv);
      logic [127:0] res;
      int src;
      res = d;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
            res[127-8*(4*c+r) -: 8] = d[127-8*(4*src+r) -: 8];
         end
      end
      return res;
   endfunction

   logic [127:0]     rot_data;
   logic [PIPE_STAGES-1:0] stage_valid;
   logic [PIPE_STAGES-1:0] stage_load;
   logic [127:0]     stage_data [PIPE_STAGES];
   logic [TAG_W-1:0] stage_tag  [PIPE_STAGES];
   logic [2:0]       count_q;
   logic             in_accept;
   logic             out_accept;

`ifdef AES_SHIFT_ROWS_BYPASS_EN
   assign rot_data = i_bypass ? i_data : shift_rows(i_data, i_inv);
`else
   assign rot_data = shift_rows(i_data, i_inv);
`endif

   // A stage loads when any stage from it to the output is empty, or the output is being taken.
   always_comb begin
      stage_load = '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
         stage_load[k] = i_ready;
         for (int j = k; j < PIPE_STAGES; j++) begin
            if (!stage_valid[j]) begin
               stage_load[k] = 1'b1;
            end
         end
      end
   end

   assign o_ready    = stage_load[0];
   assign o_valid    = stage_valid[PIPE_STAGES-1];
   assign o_data     = stage_data[PIPE_STAGES-1];
   assign o_tag      = stage_tag[PIPE_STAGES-1];
   assign o_count    = count_q;
   assign in_accept  = i_valid && o_ready;
   assign out_accept = o_valid && i_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_valid[0] <= 1'b0;
         stage_data[0]  <= '0;
         stage_tag[0]   <= '0;
      end else if (stage_load[0]) begin
         stage_valid[0] <= i_valid;
         if (i_valid) begin
            stage_data[0] <= rot_data;
            stage_tag[0]  <= i_tag;
         end
      end
   end

   // Later stages keep stale data/tag when loading a bubble; only the valid bit is cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k < PIPE_STAGES; k++) begin
            stage_valid[k] <= 1'b0;
            stage_data[k]  <= '0;
            stage_tag[k]   <= '0;
         end
      end else begin
         for (int k = 1; k < PIPE_STAGES; k++) begin
            if (stage_load[k]) begin
               stage_valid[k] <= stage_valid[k-1];
               if (stage_valid[k-1]) begin
                  stage_data[k] <= stage_data[k-1];
                  stage_tag[k]  <= stage_tag[k-1];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 3'd0;
      end else if (in_accept && !out_accept) begin
         count_q <= count_q + 3'd1;
      end else if (out_accept && !in_accept) begin
         count_q <= count_q - 3'd1;
      end
   end

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Directed bench for aes_shift_rows_pipe: a 1-stage and a 3-stage instance driven side by side.
module tb_aes_shift_rows_pipe;

   localparam logic [127:0] VEC_A   = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] VEC_B   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] VEC_C   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] VEC_C_F = 128'h00050a0f04090e03080d02070c01060b;
   localparam logic [127:0] VEC_C_I = 128'h000d0a0704010e0b0805020f0c090603;

   logic clk;
   logic rst_n;

   logic         i_valid1, i_inv1, i_ready1, o_ready1, o_valid1;
   logic [127:0] i_data1, o_data1;
   logic [3:0]   i_tag1, o_tag1;
   logic [2:0]   o_count1;

   logic         i_valid3, i_inv3, i_ready3, o_ready3, o_valid3;
   logic [127:0] i_data3, o_data3;
   logic [3:0]   i_tag3, o_tag3;
   logic [2:0]   o_count3;

`ifdef AES_SHIFT_ROWS_BYPASS_EN
   logic i_bypass1;
   logic i_bypass3;
`endif

   int checks;
   int errors;

   aes_shift_rows_pipe #(.PIPE_STAGES(1), .TAG_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .i_valid(i_valid1), .o_ready(o_ready1), .i_data(i_data1), .i_inv(i_inv1), .i_tag(i_tag1),
`ifdef AES_SHIFT_ROWS_BYPASS_EN
      .i_bypass(i_bypass1),
`endif
      .o_valid(o_valid1), .i_ready(i_ready1), .o_data(o_data1), .o_tag(o_tag1), .o_count(o_count1)
   );

   aes_shift_rows_pipe #(.PIPE_STAGES(3), .TAG_W(4)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .i_valid(i_valid3), .o_ready(o_ready3), .i_data(i_data3), .i_inv(i_inv3), .i_tag(i_tag3),
`ifdef AES_SHIFT_ROWS_BYPASS_EN
      .i_bypass(i_bypass3),
`endif
      .o_valid(o_valid3), .i_ready(i_ready3), .o_data(o_data3), .o_tag(o_tag3), .o_count(o_count3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int sel, input logic valid, input logic [127:0] data,
                                input logic inv, input logic [3:0] tag);
      if (sel == 1) begin
         i_valid1 = valid; i_data1 = data; i_inv1 = inv; i_tag1 = tag;
      end else begin
         i_valid3 = valid; i_data3 = data; i_inv3 = inv; i_tag3 = tag;
      end
   endtask

   // Uniform-byte XOR commutes with any byte permutation, so expected rotations follow from VEC_C_F.
   function automatic logic [127:0] beat_data(input int k);
      return VEC_C ^ {16{8'(k)}};
   endfunction

   function automatic logic [127:0] beat_expect(input int k);
      return VEC_C_F ^ {16{8'(k)}};
   endfunction

   initial begin
      int send_idx;
      int rx_idx;
      logic acc;

      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      i_ready1 = 1'b0;
      i_ready3 = 1'b0;
`ifdef AES_SHIFT_ROWS_BYPASS_EN
      i_bypass1 = 1'b0;
      i_bypass3 = 1'b0;
`endif
      applyStimulus(1, 1'b0, '0, 1'b0, 4'h0);
      applyStimulus(3, 1'b0, '0, 1'b0, 4'h0);
      step();
      step();

      checkOutput("reset_o_valid", {127'b0, o_valid1}, 128'd0);
      checkOutput("reset_o_data",  o_data1, 128'd0);
      checkOutput("reset_o_tag",   {124'b0, o_tag1}, 128'd0);
      checkOutput("reset_o_count", {125'b0, o_count1}, 128'd0);
      checkOutput("reset_o_valid3", {127'b0, o_valid3}, 128'd0);
      rst_n = 1'b1;
      step();
      checkOutput("idle_o_ready1", {127'b0, o_ready1}, 128'd1);
      checkOutput("idle_o_ready3", {127'b0, o_ready3}, 128'd1);

      // Back-to-back beats with alternating direction through the 1-stage instance.
      i_ready1 = 1'b1;
      applyStimulus(1, 1'b1, VEC_A, 1'b0, 4'h5);
      step();
      checkOutput("fwd_valid", {127'b0, o_valid1}, 128'd1);
      checkOutput("fwd_data",  o_data1, VEC_B);
      checkOutput("fwd_tag",   {124'b0, o_tag1}, 128'd5);
      applyStimulus(1, 1'b1, VEC_B, 1'b1, 4'h9);
      step();
      checkOutput("inv_data",  o_data1, VEC_A);
      checkOutput("inv_tag",   {124'b0, o_tag1}, 128'd9);
      checkOutput("stream_count", {125'b0, o_count1}, 128'd1);
      applyStimulus(1, 1'b1, VEC_C, 1'b0, 4'h3);
      step();
      checkOutput("fwd_c_data", o_data1, VEC_C_F);
      applyStimulus(1, 1'b1, VEC_C, 1'b1, 4'hc);
      step();
      checkOutput("inv_c_data", o_data1, VEC_C_I);
      checkOutput("inv_c_tag",  {124'b0, o_tag1}, 128'd12);
      applyStimulus(1, 1'b0, VEC_A, 1'b0, 4'h1);
      step();
      checkOutput("drain_valid", {127'b0, o_valid1}, 128'd0);
      checkOutput("drain_count", {125'b0, o_count1}, 128'd0);

      // Output hold under backpressure, and ready following i_ready combinationally.
      i_ready1 = 1'b0;
      applyStimulus(1, 1'b1, VEC_A, 1'b0, 4'h7);
      step();
      applyStimulus(1, 1'b1, VEC_C, 1'b1, 4'h2);
      #1;
      checkOutput("full_o_ready1", {127'b0, o_ready1}, 128'd0);
      step();
      checkOutput("hold_data", o_data1, VEC_B);
      checkOutput("hold_tag",  {124'b0, o_tag1}, 128'd7);
      i_ready1 = 1'b1;
      #1;
      checkOutput("ready_follows", {127'b0, o_ready1}, 128'd1);
      step();
      checkOutput("after_hold_data", o_data1, VEC_C_I);
      checkOutput("after_hold_tag",  {124'b0, o_tag1}, 128'd2);
      checkOutput("full_swap_count", {125'b0, o_count1}, 128'd1);
      applyStimulus(1, 1'b0, '0, 1'b0, 4'h0);
      step();

      // Fill the 3-stage instance with i_ready low.
      send_idx = 1;
      applyStimulus(3, 1'b1, beat_data(1), 1'b0, 4'd1);
      step();
      applyStimulus(3, 1'b1, beat_data(2), 1'b0, 4'd2);
      step();
      applyStimulus(3, 1'b1, beat_data(3), 1'b0, 4'd3);
      step();
      applyStimulus(3, 1'b1, beat_data(4), 1'b0, 4'd4);
      send_idx = 4;
      #1;
      checkOutput("bp_count",   {125'b0, o_count3}, 128'd3);
      checkOutput("bp_o_ready", {127'b0, o_ready3}, 128'd0);
      checkOutput("bp_data",    o_data3, beat_expect(1));
      step();
      step();
      checkOutput("bp_held_data", o_data3, beat_expect(1));
      checkOutput("bp_held_tag",  {124'b0, o_tag3}, 128'd1);
      i_ready3 = 1'b1;
      #1;
      checkOutput("bp_ready_rise", {127'b0, o_ready3}, 128'd1);

      rx_idx = 1;
      for (int cyc = 0; cyc < 20 && rx_idx <= 5; cyc++) begin
         if (o_valid3) begin
            checkOutput("order_tag",  {124'b0, o_tag3}, 128'(rx_idx));
            checkOutput("order_data", o_data3, beat_expect(rx_idx));
            rx_idx++;
         end
         acc = i_valid3 && o_ready3;
         step();
         if (acc) begin
            send_idx++;
            if (send_idx <= 5) applyStimulus(3, 1'b1, beat_data(send_idx), 1'b0, 4'(send_idx));
            else               applyStimulus(3, 1'b0, '0, 1'b0, 4'h0);
         end
      end
      checkOutput("beats_received", 128'(rx_idx - 1), 128'd5);
      step();
      checkOutput("no_duplicate", {127'b0, o_valid3}, 128'd0);
      checkOutput("empty_count",  {125'b0, o_count3}, 128'd0);

      // Bubble collapse: a stalled beat at the output must not block a new one.
      i_ready3 = 1'b0;
      applyStimulus(3, 1'b1, beat_data(6), 1'b0, 4'd6);
      step();
      applyStimulus(3, 1'b0, '0, 1'b0, 4'h0);
      for (int i = 0; i < 4; i++) step();
      applyStimulus(3, 1'b1, beat_data(7), 1'b0, 4'd7);
      #1;
      checkOutput("bubble_o_ready", {127'b0, o_ready3}, 128'd1);
      step();
      applyStimulus(3, 1'b0, '0, 1'b0, 4'h0);
      checkOutput("bubble_count", {125'b0, o_count3}, 128'd2);
      checkOutput("bubble_tag",   {124'b0, o_tag3}, 128'd6);

      // Asynchronous reset mid-stream drops both in-flight beats.
      rst_n = 1'b0;
      #1;
      checkOutput("rst_o_valid", {127'b0, o_valid3}, 128'd0);
      checkOutput("rst_o_data",  o_data3, 128'd0);
      checkOutput("rst_o_count", {125'b0, o_count3}, 128'd0);
      step();
      rst_n = 1'b1;
      i_ready3 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("no_stale_beat", {127'b0, o_valid3}, 128'd0);
      end

`ifdef AES_SHIFT_ROWS_BYPASS_EN
      i_bypass1 = 1'b1;
      applyStimulus(1, 1'b1, VEC_C, 1'b1, 4'ha);
      step();
      checkOutput("bypass_data", o_data1, VEC_C);
      checkOutput("bypass_tag",  {124'b0, o_tag1}, 128'd10);
      i_bypass1 = 1'b0;
      applyStimulus(1, 1'b1, VEC_C, 1'b1, 4'hb);
      step();
      checkOutput("no_bypass_data", o_data1, VEC_C_I);
      applyStimulus(1, 1'b0, '0, 1'b0, 4'h0);
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_shift_rows_pipe.md
# aes_shift_rows_pipe

Parametrised, elastic ShiftRows/InvShiftRows stage for the AES datapath. It accepts one 128-bit state per beat over a valid/ready handshake, selects forward or inverse row rotation per beat, and carries a sideband tag through a configurable-depth register pipeline with full backpressure. It sits between the SubBytes/InvSubBytes and MixColumns/InvMixColumns stages of the shared encrypt/decrypt round datapath.

## Interface
- PIPE_STAGES, 1: number of register stages, legal range 1..4; sets the latency.
- TAG_W, 4: sideband tag width, minimum 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  input beat present.
- o_ready  output  1  stage 0 can accept a beat this cycle.
- i_data  input  128  state in; byte s[r,c] = i_data[127-8*(4c+r) -: 8].
- i_inv  input  1  0 = ShiftRows, 1 = InvShiftRows for this beat.
- i_tag  input  TAG_W  sideband, passed through unmodified.
- o_valid  output  1  output beat present.
- i_ready  input  1  downstream accepts the output beat.
- o_data  output  128  rotated state, same byte layout.
- o_tag  output  TAG_W  tag of the output beat.
- o_count  output  3  number of beats held in the pipeline, 0..PIPE_STAGES.

## Operation
- Forward: out[r,c] = in[r,(c+r) mod 4]. Inverse: out[r,c] = in[r,(c-r) mod 4]. Row 0 is never moved.
- Rotation is combinational on i_data and is registered into stage 0 together with i_tag and a valid bit. Stages 1..PIPE_STAGES-1 are plain data/tag/valid registers.
- Per-stage load rule: stage k loads when its valid bit is clear or stage k+1 loads. The last stage loads when !o_valid or i_ready.
- o_ready is the stage-0 load enable. This gives a combinational ready path from i_ready through the stages, with no skid buffer.
- Bubbles collapse: an empty stage always loads, so a stall in a later stage does not block an earlier empty stage.
- A stage that loads while its upstream is not valid clears its valid bit. Its data and tag registers keep their old values.
- o_count increments on input accept (i_valid && o_ready) without output accept (o_valid && i_ready). It decrements on the reverse case and is unchanged when both or neither occur.
- Reset clears every valid bit, data register, tag register and o_count. Reset asserted mid-stream drops all in-flight beats with no output.
- Out-of-range PIPE_STAGES is an elaboration error: a generate block instantiates an undefined module.

## Timing
- Reset values: o_valid=0, o_data=128'h0, o_tag=0, o_count=0. o_ready=1 while out of reset with an empty pipeline.
- Latency is PIPE_STAGES cycles from input accept to o_valid with unstalled flow.
- Throughput is one beat per cycle while i_ready=1, including back-to-back beats with alternating i_inv.
- While o_valid=1 and i_ready=0, o_data and o_tag are held stable.
- Full pipeline (o_count=PIPE_STAGES) with i_ready=0 forces o_ready=0. If i_ready rises, o_ready rises in the same cycle.
- Simultaneous accept on input and output with a full pipeline is legal; o_count is unchanged.
- i_data, i_inv and i_tag are ignored when i_valid=0.

## Configuration
- AES_SHIFT_ROWS_BYPASS_EN defined: adds input port i_bypass (1 bit), sampled with the beat. When i_bypass=1 the beat passes unrotated (out=in) and i_inv is ignored. This serves the initial AddRoundKey-only pass. Latency and handshake are unchanged.
- Not defined: there is no i_bypass port, and every beat is rotated according to i_inv.

## Test plan
- Forward rotation, PIPE_STAGES=1: i_data=d42711aee0bf98f1b8b45de51e415230, i_inv=0, i_tag=5 -> one cycle later o_data=d4bf5d30e0b452aeb84111f11e2798e5, o_tag=5, o_valid=1.
- Inverse rotation: i_data=d4bf5d30e0b452aeb84111f11e2798e5, i_inv=1 -> o_data=d42711aee0bf98f1b8b45de51e415230.
- Backpressure, PIPE_STAGES=3: send 5 beats with i_ready=0 -> o_count=3, o_ready=0, o_data held. Then raise i_ready -> all 5 beats emerge in order with correct tags and no duplicates.
- Bubble collapse, PIPE_STAGES=3: send one beat, hold i_ready=0 for 4 cycles, then send a second beat -> the second beat is accepted (o_ready=1) and o_count=2.
- Reset mid-stream: with o_count=2, pulse rst_n low for 1 cycle -> o_valid=0, o_data=0, o_count=0 immediately. No stale beat appears after release.
- With AES_SHIFT_ROWS_BYPASS_EN: i_bypass=1, i_inv=1, i_data=000102030405060708090a0b0c0d0e0f -> o_data=000102030405060708090a0b0c0d0e0f.
